// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage sitting directly upstream of decode.
// It holds the fetch PC and issues single-word reads to instruction memory
// over a req/gnt/rvalid handshake, with at most one read outstanding. The
// returned words go into a 2-entry queue: an output register that drives
// insn/pc, plus a skid entry behind it. The head is qualified by
// enable_decode. A redirect reloads the fetch PC and flushes everything in
// flight.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          decode cannot accept the head entry this cycle
//   redirect       load redirect_pc and flush queue / in-flight read
//   redirect_pc    new fetch target (bits [1:0] ignored)
//   mem_req        read request valid
//   mem_addr       word-aligned read address
//   mem_gnt        memory accepts the request this cycle
//   mem_rvalid     read data valid
//   mem_rdata      returned instruction word
//   insn           instruction presented to decode
//   pc             address of insn
//   enable_decode  insn/pc valid
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8002_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        enable_decode
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [1:0] DEPTH = QDEPTH[1:0];

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] skid_insn;
    logic [31:0] skid_pc;
    logic        skid_valid;
    logic        active;
    logic [1:0]  count;
    logic        granted;
    logic        push;
    logic        pop;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};
    assign count  = {1'b0, enable_decode} + {1'b0, skid_valid};

    // Requests are only raised in FETCH, where nothing is outstanding, so the
    // queue-occupancy test alone keeps (count + outstanding) within the depth.
    // The queue cannot drain into FETCH without a pop, so once raised mem_req
    // stays high until granted. 'active' keeps mem_req low while reset is held.
    assign mem_req  = active && (state == FETCH) && (count < DEPTH);
    assign mem_addr = fetch_pc;
    assign granted  = mem_req && mem_gnt;

    // Responses are accepted only in WAIT. A response arriving together with
    // a redirect is dropped.
    assign push = (state == WAIT) && mem_rvalid && !redirect;
    assign pop  = enable_decode && !stall;

    // Fetch control
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            active   <= 1'b0;
        end else begin
            active <= 1'b1;
            if (redirect) begin
                fetch_pc <= target;
                // A read granted in this same cycle, or one still awaiting
                // its response, must be drained before a new request goes out.
                case (state)
                    FETCH:   state <= granted    ? DRAIN : FETCH;
                    WAIT:    state <= mem_rvalid ? FETCH : DRAIN;
                    DRAIN:   state <= mem_rvalid ? FETCH : DRAIN;
                    default: state <= FETCH;
                endcase
            end else begin
                case (state)
                    FETCH: begin
                        if (granted) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= WAIT;
                        end
                    end
                    WAIT, DRAIN: begin
                        if (mem_rvalid) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    // Output queue: the head lives in insn/pc/enable_decode, and the skid
    // entry sits behind it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            insn          <= '0;
            pc            <= '0;
            enable_decode <= 1'b0;
            skid_insn     <= '0;
            skid_pc       <= '0;
            skid_valid    <= 1'b0;
        end else if (redirect) begin
            enable_decode <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (enable_decode && !pop) begin
            // Head is held for decode; a new word can only land in the skid
            // entry, which request gating guarantees is free here.
            if (push) begin
                skid_insn  <= mem_rdata;
                skid_pc    <= req_pc;
                skid_valid <= 1'b1;
            end
        end else if (skid_valid) begin
            // Head consumed (or empty): promote the skid entry, then refill
            // it with any word arriving in the same cycle.
            insn          <= skid_insn;
            pc            <= skid_pc;
            enable_decode <= 1'b1;
            if (push) begin
                skid_insn <= mem_rdata;
                skid_pc   <= req_pc;
            end else begin
                skid_valid <= 1'b0;
            end
        end else begin
            if (push) begin
                insn          <= mem_rdata;
                pc            <= req_pc;
                enable_decode <= 1'b1;
            end else begin
                enable_decode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. It contains a
// behavioural memory (with an address-hashed instruction image and a random
// response latency) and a transaction-level model. The model keeps the
// decode-visible queue as a list of fetched addresses, the next fetch address,
// and the single outstanding read together with whether it has been made
// stale by a redirect.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        enable_decode;

    fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .insn          (insn),
        .pc            (pc),
        .enable_decode (enable_decode)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] seen[$];
    logic [31:0] next_fetch = RESET_PC;
    logic [31:0] resp_pc = '0;
    bit          outstanding = 1'b0;
    bit          stale = 1'b0;
    bit          started = 1'b0;
    bit          redir_applied = 1'b0;
    int          lat_cnt = 0;
    int          lat_min = 0;
    int          lat_max = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_checks();
        check("enable_decode", 32'(enable_decode), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("pc", pc, q[0]);
            check("insn", insn, memfn(q[0]));
        end
        check("queue_depth", 32'(q.size() <= 2), 32'd1);
        check("addr_align", 32'(mem_addr[1:0]), 32'd0);
        if (started) begin
            check("mem_req", 32'(mem_req), 32'(!outstanding && q.size() < 2));
            if (mem_req) check("mem_addr", mem_addr, next_fetch);
        end
    endtask

    // One clock cycle: entered and left in the low phase of the clock.
    // Redirect modes: 0 none, 1 always, 2 only with a real rvalid this
    // cycle, 3 only while a read is pending and no rvalid this cycle.
    task automatic cycle(input bit gnt_en, input int mode, input logic [31:0] rpc,
                         input bit st, input bit orphan);
        bit          rv;
        bit          req_e;
        logic [31:0] addr_e;
        logic [31:0] pc_e;
        bit          granted;
        bit          delivered;
        bit          popped;

        run_checks();
        rv = 1'b0;
        if (outstanding) begin
            if (lat_cnt == 0) rv = 1'b1;
            else lat_cnt--;
        end
        mem_rvalid  = rv || orphan;
        mem_rdata   = rv ? memfn(resp_pc) : $urandom;
        mem_gnt     = gnt_en;
        stall       = st;
        redirect    = (mode == 1) || (mode == 2 && rv) || (mode == 3 && outstanding && !rv);
        redirect_pc = rpc;
        redir_applied = redirect;
        req_e  = mem_req;
        addr_e = mem_addr;
        pc_e   = pc;

        @(posedge clock);
        granted   = req_e && mem_gnt;
        delivered = rv && !stale && !redirect;
        popped    = (q.size() != 0) && !stall && !redirect;
        if (rv) outstanding = 1'b0;
        if (redirect) begin
            q.delete();
            if (outstanding) stale = 1'b1;
            next_fetch = {redirect_pc[31:2], 2'b00};
        end else begin
            if (popped) begin
                void'(q.pop_front());
                seen.push_back(pc_e);
            end
            if (delivered) q.push_back(resp_pc);
        end
        if (granted) begin
            outstanding = 1'b1;
            stale       = redirect;
            resp_pc     = addr_e;
            lat_cnt     = int'($urandom_range(lat_max, lat_min));
            if (!redirect) next_fetch = addr_e + 32'd4;
        end
        started = 1'b1;
        @(negedge clock);
        redirect   = 1'b0;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
    endtask

    // Entered in the low phase of the clock; reset takes effect immediately.
    task automatic do_reset(input bit orphan);
        reset      = 1'b1;
        redirect   = 1'b0;
        mem_gnt    = 1'b0;
        stall      = 1'b0;
        mem_rvalid = orphan;
        mem_rdata  = $urandom;
        #1;
        check("rst_enable", 32'(enable_decode), 32'd0);
        check("rst_insn", insn, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        q.delete();
        outstanding = 1'b0;
        stale       = 1'b0;
        started     = 1'b0;
        next_fetch  = RESET_PC;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset      = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        bit found;
        #2;
        do_reset(1'b0);

        // Zero-wait streaming, then stall while 0x80020004 is presented
        lat_min = 0; lat_max = 0;
        seen.delete();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (enable_decode && pc == 32'h8002_0004) found = 1'b1;
            else cycle(1'b1, 0, '0, 1'b0, 1'b0);
        end
        check("stall_target_seen", 32'(found), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 0, '0, 1'b1, 1'b0);
            check("stall_hold_pc", pc, 32'h8002_0004);
            check("stall_hold_insn", insn, memfn(32'h8002_0004));
        end
        check("stall_full_no_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 0, '0, 1'b0, 1'b0);
        if (seen.size() >= 4) begin
            check("seq0", seen[0], 32'h8002_0000);
            check("seq1", seen[1], 32'h8002_0004);
            check("seq2", seen[2], 32'h8002_0008);
            check("seq3", seen[3], 32'h8002_000C);
        end else begin
            check("seq_count", seen.size(), 32'd4);
        end

        // Latency 3, redirect one cycle after the grant -> stale read drained
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b1, 0, '0, 1'b0, 1'b0);
            if (outstanding && !stale) found = 1'b1;
        end
        check("drain_grant_seen", 32'(found), 32'd1);
        seen.delete();
        cycle(1'b1, 1, 32'h8003_0010, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 0, '0, 1'b0, 1'b0);
        if (seen.size() >= 1) check("drain_first_pc", seen[0], 32'h8003_0010);
        else check("drain_count", seen.size(), 32'd1);

        // Redirect coinciding with rvalid
        lat_min = 0; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(1'b1, 2, 32'h8003_0013, 1'b0, 1'b0);
            found = redir_applied;
        end
        check("rv_redirect_seen", 32'(found), 32'd1);
        check("rv_redirect_addr", mem_addr, 32'h8003_0010);
        check("rv_redirect_req", 32'(mem_req), 32'd1);
        seen.delete();
        for (int i = 0; i < 10; i++) cycle(1'b1, 0, '0, 1'b0, 1'b0);
        if (seen.size() >= 1) check("rv_redirect_first_pc", seen[0], 32'h8003_0010);
        else check("rv_redirect_count", seen.size(), 32'd1);

        // Reset while a read is pending with the queue occupied
        lat_min = 4; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(1'b1, 0, '0, 1'b1, 1'b0);
            if (outstanding && q.size() >= 1) found = 1'b1;
        end
        check("reset_wait_seen", 32'(found), 32'd1);
        do_reset(1'b1);
        cycle(1'b0, 0, '0, 1'b0, 1'b1);
        lat_min = 0; lat_max = 1;
        seen.delete();
        for (int i = 0; i < 12; i++) cycle(1'b1, 0, '0, 1'b0, 1'b0);
        if (seen.size() >= 1) check("reset_resume_pc", seen[0], RESET_PC);
        else check("reset_resume_count", seen.size(), 32'd1);

        // Wraparound of the fetch address
        lat_min = 0; lat_max = 0;
        seen.delete();
        cycle(1'b1, 1, 32'hFFFF_FFF8, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 0, '0, 1'b0, 1'b0);
        if (seen.size() >= 3) begin
            check("wrap0", seen[0], 32'hFFFF_FFF8);
            check("wrap1", seen[1], 32'hFFFF_FFFC);
            check("wrap2", seen[2], 32'h0000_0000);
        end else begin
            check("wrap_count", seen.size(), 32'd3);
        end

        // Randomized traffic
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset($urandom_range(1, 0) == 1);
            end else begin
                int          mode;
                logic [31:0] rpc;
                mode = ($urandom_range(15, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
                rpc  = $urandom_range(1, 0) == 1 ? $urandom : (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)));
                cycle($urandom_range(3, 0) != 0, mode, rpc, $urandom_range(2, 0) == 0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
